// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier family: FSM states, digit size
// and width helpers used to size the iterative datapath.
package vedic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DIGIT = 4;

   // Number of 4-bit digits in a w-bit operand.
   function automatic int D(input int w);
      return w / DIGIT;
   endfunction

   // Number of digit-pair partial products for a w x w multiply.
   function automatic int N(input int w);
      return D(w) * D(w);
   endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from
// four 2x2 vertical-and-crosswise cells.
module vedic_4x4
   import vedic_pkg::*;
(
   input  logic [DIGIT-1:0]   a_i,
   input  logic [DIGIT-1:0]   b_i,
   output logic [2*DIGIT-1:0] p_o
);

   logic [3:0] ppLowLow;
   logic [3:0] ppHighLow;
   logic [3:0] ppLowHigh;
   logic [3:0] ppHighHigh;
   logic [4:0] crossSum;

   function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
      logic t1, t2, t3, c1;
      t1 = x[1] & y[0];
      t2 = x[0] & y[1];
      t3 = x[1] & y[1];
      c1 = t1 & t2;
      return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
   endfunction

   // Vertical products at the ends, crosswise products summed in the middle.
   always_comb begin
      ppLowLow   = vedic2x2(a_i[1:0], b_i[1:0]);
      ppHighLow  = vedic2x2(a_i[3:2], b_i[1:0]);
      ppLowHigh  = vedic2x2(a_i[1:0], b_i[3:2]);
      ppHighHigh = vedic2x2(a_i[3:2], b_i[3:2]);
      crossSum   = {1'b0, ppHighLow} + {1'b0, ppLowHigh};
      p_o        = {4'b0000, ppLowLow} + {1'b0, crossSum, 2'b00} + {ppHighHigh, 4'b0000};
   end

endmodule

// File: rtl/vedic_mul_seq.sv
// Iterative W x W unsigned multiplier. One vedic_4x4 core is time-shared over
// every digit pair; each MUL cycle adds one shifted partial product into a
// 2W-bit accumulator. Operands of zero short-circuit straight to DONE.
module vedic_mul_seq
   import vedic_pkg::*;
#(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] y,
   output logic           busy
);

   localparam int ND = D(W);
   localparam int IW = (ND > 1) ? $clog2(ND) : 1;
   localparam int SW = $clog2(2 * W);
   localparam logic [IW-1:0] LAST = IW'(ND - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     opA_q, opA_d;
   logic [W-1:0]     opB_q, opB_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   y_q, y_d;
   logic [IW-1:0]    idxI_q, idxI_d;
   logic [IW-1:0]    idxJ_q, idxJ_d;

   logic [DIGIT-1:0]   coreA;
   logic [DIGIT-1:0]   coreB;
   logic [2*DIGIT-1:0] corePp;
   logic [SW-1:0]      shAmt;
   logic [2*W-1:0]     ppShifted;
   logic [2*W-1:0]     accSum;
   logic               lastStep;
   logic               zeroOp;

   vedic_4x4 u_core (
      .a_i (coreA),
      .b_i (coreB),
      .p_o (corePp)
   );

   // Select the current digit pair, weight its product by 4*(i+j) and add.
   always_comb begin
      coreA     = opA_q[DIGIT*idxI_q +: DIGIT];
      coreB     = opB_q[DIGIT*idxJ_q +: DIGIT];
      shAmt     = (SW'(idxI_q) + SW'(idxJ_q)) << 2;
      ppShifted = {{(2*W-2*DIGIT){1'b0}}, corePp} << shAmt;
      accSum    = acc_q + ppShifted;
      lastStep  = (idxI_q == LAST) && (idxJ_q == LAST);
      zeroOp    = (opA_q == '0) || (opB_q == '0);
   end

   // Next-state logic: accept in IDLE, step digits in MUL, hold result in DONE.
   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      acc_d   = acc_q;
      y_d     = y_q;
      idxI_d  = idxI_q;
      idxJ_d  = idxJ_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opA_d   = a;
               opB_d   = b;
               acc_d   = '0;
               idxI_d  = '0;
               idxJ_d  = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            if (zeroOp) begin
               acc_d   = '0;
               y_d     = '0;
               state_d = DONE;
            end else begin
               acc_d = accSum;
               if (idxI_q == LAST) begin
                  idxI_d = '0;
                  idxJ_d = idxJ_q + 1'b1;
               end else begin
                  idxI_d = idxI_q + 1'b1;
               end
               if (lastStep) begin
                  idxJ_d  = '0;
                  y_d     = accSum;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any in-flight product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         idxI_q  <= '0;
         idxJ_q  <= '0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         idxI_q  <= idxI_d;
         idxJ_q  <= idxJ_d;
      end
   end

   // Handshake outputs decoded purely from the registered state.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      y         = y_q;
   end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Self-checking bench for vedic_mul_seq: directed vectors, backpressure,
// reset abort, randomized back-to-back products and a 32-bit build.
module tb_vedic_mul_seq;

   localparam int W   = 16;
   localparam int NPP = (W / 4) * (W / 4);

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] y;
      int          lat;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        busy;

   logic        in_valid32;
   logic        in_ready32;
   logic [31:0] a32;
   logic [31:0] b32;
   logic        out_valid32;
   logic        out_ready32;
   logic [63:0] y32;
   logic        busy32;

   int checks   = 0;
   int failures = 0;
   int edgeCnt  = 0;

   vec_t        vecs[7];
   logic [31:0] yv;
   int          lat;
   bit          stateOk;
   bit          holdOk;
   int          guard;
   int          accEdge;
   int          prevAcc;
   int          prevGap;
   logic [15:0] ra;
   logic [15:0] rb;

   vedic_mul_seq #(.W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   vedic_mul_seq #(.W(32)) dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .a         (a32),
      .b         (b32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .y         (y32),
      .busy      (busy32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt++;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Waits for IDLE, offers one operand pair, then counts edges to out_valid.
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                output logic [31:0] yOut, output int latOut, output bit stOk);
      int g;
      g    = 0;
      stOk = 1'b1;
      while (in_ready !== 1'b1 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      checkOutput("acceptReady", 64'(in_ready), 64'(1));
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      latOut   = 0;
      while (out_valid !== 1'b1 && latOut < 200) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) stOk = 1'b0;
         @(posedge clk);
         #1;
         latOut++;
      end
      if (in_ready !== 1'b0 || busy !== 1'b1) stOk = 1'b0;
      yOut = y;
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      out_ready   = 1'b1;
      in_valid32  = 1'b0;
      a32         = '0;
      b32         = '0;
      out_ready32 = 1'b1;

      vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, NPP};
      vecs[1] = '{16'h0000, 16'h1234, 32'h00000000, 1};
      vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 1};
      vecs[3] = '{16'h00FF, 16'h0101, 32'h0000FFFF, NPP};
      vecs[4] = '{16'h1234, 16'h5678, 32'h06260060, NPP};
      vecs[5] = '{16'h0003, 16'h0005, 32'h0000000F, NPP};
      vecs[6] = '{16'h8000, 16'h0002, 32'h00010000, NPP};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstInReady", 64'(in_ready), 64'(1));
      checkOutput("rstOutValid", 64'(out_valid), 64'(0));
      checkOutput("rstBusy", 64'(busy), 64'(0));
      checkOutput("rstY", 64'(y), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 7; k++) begin
         applyStimulus(vecs[k].a, vecs[k].b, yv, lat, stateOk);
         checkOutput($sformatf("vecY[%0d]", k), 64'(yv), 64'(vecs[k].y));
         checkOutput($sformatf("vecLatency[%0d]", k), 64'(lat), 64'(vecs[k].lat));
         checkOutput($sformatf("vecBusyFlags[%0d]", k), 64'(stateOk), 64'(1));
      end

      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(16'h00FF, 16'h0101, yv, lat, stateOk);
      checkOutput("bpY", 64'(yv), 64'(32'h0000FFFF));
      checkOutput("bpLatency", 64'(lat), 64'(NPP));
      holdOk = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         a        = 16'($urandom);
         b        = 16'($urandom);
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || y !== 32'h0000FFFF || in_ready !== 1'b0) holdOk = 1'b0;
      end
      in_valid = 1'b0;
      checkOutput("bpHold", 64'(holdOk), 64'(1));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("bpReleaseOutValid", 64'(out_valid), 64'(0));
      checkOutput("bpReleaseInReady", 64'(in_ready), 64'(1));
      checkOutput("bpRetainY", 64'(y), 64'(32'h0000FFFF));

      out_ready = 1'b1;
      a         = 16'h1234;
      b         = 16'h5678;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstOutValid", 64'(out_valid), 64'(0));
      checkOutput("midRstInReady", 64'(in_ready), 64'(1));
      checkOutput("midRstBusy", 64'(busy), 64'(0));
      checkOutput("midRstY", 64'(y), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(16'h0003, 16'h0005, yv, lat, stateOk);
      checkOutput("postRstY", 64'(yv), 64'(32'h0000000F));
      checkOutput("postRstLatency", 64'(lat), 64'(NPP));

      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      prevAcc   = -1;
      prevGap   = 0;
      for (int k = 0; k < 1000; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (k % 50 == 7)  ra = 16'h0000;
         if (k % 50 == 23) rb = 16'h0000;
         guard = 0;
         while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
         end
         a = ra;
         b = rb;
         @(posedge clk);
         #1;
         accEdge = edgeCnt;
         if (prevAcc >= 0) checkOutput("b2bSpacing", 64'(accEdge - prevAcc), 64'(prevGap));
         a     = 16'($urandom);
         b     = 16'($urandom);
         guard = 0;
         while (out_valid !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
         end
         checkOutput("b2bProduct", 64'(y), 64'(32'(ra) * 32'(rb)));
         prevAcc = accEdge;
         prevGap = (ra == 0 || rb == 0) ? 3 : NPP + 2;
      end
      in_valid = 1'b0;

      @(posedge clk);
      #1;
      guard = 0;
      while (in_ready32 !== 1'b1 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      a32        = 32'hFFFFFFFF;
      b32        = 32'hFFFFFFFF;
      in_valid32 = 1'b1;
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      a32        = '0;
      b32        = '0;
      lat        = 0;
      while (out_valid32 !== 1'b1 && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("w32Y", y32, 64'hFFFFFFFE00000001);
      checkOutput("w32Latency", 64'(lat), 64'(64));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
